// File: rtl/arithmetic_div.sv
// arithmetic_div: sequential signed divider, non-restoring radix-2, one
// quotient bit per clock. Result packs {remainder, quotient} into out.
// Optional build macro DIV_ZERO_TRAP_EN: a zero divisor skips the iterations
// and raises div_zero; without it div_zero is tied low.
module arithmetic_div #(
    parameter int WIDTH      = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     m,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_CORRECT,
        S_SIGN,
        S_DONE
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    // Operands as captured at acceptance, plus the result signs
    logic [WIDTH-1:0]       q_in_reg;
    logic [WIDTH-1:0]       m_in_reg;
    logic                   sign_q_reg;
    logic                   sign_r_reg;
    logic                   trap_reg;

    // Working registers: partial remainder A (signed), quotient Q, divisor M
    logic [WIDTH:0]         a_reg;
    logic [WIDTH-1:0]       qr_reg;
    logic [WIDTH:0]         m_reg;
    logic [ITER_CNT_W-1:0]  cnt_reg;
    logic [2*WIDTH-1:0]     out_reg;

    // Datapath helpers
    logic [WIDTH-1:0]       q_abs;
    logic [WIDTH-1:0]       m_mag;
    logic [WIDTH:0]         m_abs;
    logic [WIDTH:0]         a_shift;
    logic [WIDTH:0]         a_step;
    logic [WIDTH-1:0]       quo_signed;
    logic [WIDTH-1:0]       rem_signed;
    logic                   last_iter;
    logic                   m_is_zero;

    // |q| fits in WIDTH unsigned bits, so the most negative dividend is exact.
    // The divisor magnitude is zero-extended so A-M never overflows.
    always_comb begin
        q_abs      = sign_q_reg ? (~q_in_reg + 1'b1) : q_in_reg;
        m_mag      = m_in_reg[WIDTH-1] ? (~m_in_reg + 1'b1) : m_in_reg;
        m_abs      = {1'b0, m_mag};
        a_shift    = {a_reg[WIDTH-1:0], qr_reg[WIDTH-1]};
        a_step     = a_reg[WIDTH] ? (a_shift + m_reg) : (a_shift - m_reg);
        quo_signed = sign_r_reg ? (~qr_reg + 1'b1) : qr_reg;
        rem_signed = sign_q_reg ? (~a_reg[WIDTH-1:0] + 1'b1) : a_reg[WIDTH-1:0];
        last_iter  = (cnt_reg == ITER_CNT_W'(WIDTH - 1));
        m_is_zero  = (m == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                busy       = 1'b1;
                state_next = trap_reg ? S_DONE : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = S_CORRECT;
                end
            end
            S_CORRECT: begin
                busy       = 1'b1;
                state_next = S_SIGN;
            end
            S_SIGN: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_in_reg   <= '0;
            m_in_reg   <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            a_reg      <= '0;
            qr_reg     <= '0;
            m_reg      <= '0;
            cnt_reg    <= '0;
            out_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        q_in_reg   <= q;
                        m_in_reg   <= m;
                        sign_q_reg <= q[WIDTH-1];
                        sign_r_reg <= q[WIDTH-1] ^ m[WIDTH-1];
                    end
                end
                S_SETUP: begin
                    a_reg   <= '0;
                    qr_reg  <= q_abs;
                    m_reg   <= m_abs;
                    cnt_reg <= '0;
                    if (trap_reg) begin
                        out_reg <= {q_in_reg, {WIDTH{1'b1}}};
                    end
                end
                S_ITER: begin
                    a_reg   <= a_step;
                    qr_reg  <= {qr_reg[WIDTH-2:0], ~a_step[WIDTH]};
                    cnt_reg <= cnt_reg + 1'b1;
                end
                S_CORRECT: begin
                    if (a_reg[WIDTH]) begin
                        a_reg <= a_reg + m_reg;
                    end
                end
                S_SIGN: begin
                    out_reg <= {rem_signed, quo_signed};
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    logic dz_reg;

    // Zero-divisor trap: decided at acceptance, flag held until next start
    always_ff @(posedge clk) begin
        if (!clr) begin
            trap_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else if (state_reg == S_IDLE && start) begin
            trap_reg <= m_is_zero;
            dz_reg   <= 1'b0;
        end else if (state_reg == S_SETUP && trap_reg) begin
            dz_reg   <= 1'b1;
        end
    end

    assign div_zero = dz_reg;
`else
    // Without the trap a zero divisor simply runs the full sequence
    always_comb begin
        trap_reg = 1'b0 & m_is_zero;
    end

    assign div_zero = 1'b0;
`endif

    assign out = out_reg;

endmodule

// File: tb/tb_arithmetic_div.sv
// tb_arithmetic_div: randomized self-checking bench for arithmetic_div.
// Expected results come from 64-bit signed division in the testbench.
module tb_arithmetic_div;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] q = '0;
    logic [31:0] m = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] out;

    int tests = 0;
    int fails = 0;

    arithmetic_div #(.WIDTH(32), .ITER_CNT_W(6)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .q        (q),
        .m        (m),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating signed division; remainder follows the dividend's sign
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint qq;
        longint rr;
        x  = $signed(a);
        y  = $signed(b);
        qq = x / y;
        rr = x % y;
        return {rr[31:0], qq[31:0]};
    endfunction

    // One full transaction; k counts edges after the accepting edge
    task automatic do_op(input string tag, input logic [31:0] qv, input logic [31:0] mv, input bit noisy);
        int          done_k;
        int          busy_n;
        int          done_n;
        int          exp_k;
        logic        exp_dz;
        logic        chk_out;
        logic [63:0] exp;
        logic [63:0] out_at_done;
        exp     = model(qv, (mv == 0) ? 32'd1 : mv);
        exp_k   = 35;
        exp_dz  = 1'b0;
        chk_out = (mv != 0);
`ifdef DIV_ZERO_TRAP_EN
        if (mv == 0) begin
            exp     = {qv, 32'hFFFF_FFFF};
            exp_k   = 1;
            exp_dz  = 1'b1;
            chk_out = 1'b1;
        end
`endif
        @(negedge clk);
        q = qv;
        m = mv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_k = -1;
        busy_n = 0;
        done_n = 0;
        out_at_done = '0;
        for (int k = 0; k < 45; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    out_at_done = out;
                end
            end
            if (noisy && (k == 4 || k == 19)) begin
                start = 1'b1;
                q = $urandom;
                m = $urandom | 32'd1;
            end
        end
        check_val({tag, ".done_at"}, 64'(done_k), 64'(exp_k));
        check_val({tag, ".done_cnt"}, 64'(done_n), 64'd1);
        check_val({tag, ".busy_cnt"}, 64'(busy_n), 64'(exp_k));
        check_val({tag, ".div_zero"}, {63'd0, div_zero}, {63'd0, exp_dz});
        if (chk_out) begin
            check_val({tag, ".out"}, out_at_done, exp);
            check_val({tag, ".out_held"}, out, exp);
        end
        $display("[TB] %s q=%h m=%h out=%h done_at=%0d", tag, qv, mv, out_at_done, done_k);
    endtask

    initial begin
        int          dn;
        logic [31:0] rq;
        logic [31:0] rm;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.out", out, 64'd0);
        check_val("rst.flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        clr = 1'b1;

        do_op("pos", 32'd100, 32'd7, 1'b0);
        do_op("neg", 32'hFFFF_FF9C, 32'd7, 1'b0);
        do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("noisy", 32'd1234567, 32'hFFFF_FEBF, 1'b1);

        // Reset in the middle of an operation abandons it
        @(negedge clk);
        q = 32'd50;
        m = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst.out", out, 64'd0);
        check_val("midrst.flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        dn = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check_val("midrst.no_done", 64'(dn), 64'd0);
        do_op("after_rst", 32'd9, 32'hFFFF_FFFE, 1'b0);

`ifdef DIV_ZERO_TRAP_EN
        do_op("trap", 32'h0000_1234, 32'd0, 1'b0);
        do_op("post_trap", 32'd77, 32'hFFFF_FFFB, 1'b0);
`endif

        // Randomized operands with a bias toward small and extreme divisors
        for (int i = 0; i < 16; i++) begin
            rq = $urandom;
            if (i % 5 == 0) rq = 32'h8000_0000;
            case (i % 3)
                0: rm = $urandom_range(1, 20);
                1: rm = -($urandom_range(1, 300));
                default: rm = $urandom;
            endcase
            if (rm == 0) rm = 32'd3;
            do_op($sformatf("rnd%0d", i), rq, rm, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
